wb_awb_stats: RTL

//  Auto-white-balance statistics/gain stage, directly upstream of the per-channel white-balance core.

---
 rtl/wb_awb_stats_pkg.sv | 19 +
 rtl/wb_awb_stats_div.sv | 73 +++++++
 rtl/wb_awb_stats.sv | 121 ++++++++++++
 3 files changed

// File: rtl/wb_awb_stats_pkg.sv
// Shared AWB definitions: divider FSM states, unity-gain constant and a
// saturating adder used by the statistics accumulators.
package wb_awb_stats_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DIV, S_DONE} wb_state_e;

  function automatic int unsigned unity_gain(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

  // Result clamps at max instead of wrapping.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] max);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[63:0];
  endfunction

endpackage

// File: rtl/wb_awb_stats_div.sv
// Unsigned restoring divider, one quotient bit per cycle. Zero-divisor and
// quotient-overflow flags are combinational from the (held) operands.
module wb_seq_div #(
  parameter int NUM_W = 36,
  parameter int DEN_W = 32,
  parameter int Q_W   = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic [Q_W-1:0]   quot_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             done_o
);
  localparam int RW = DEN_W + Q_W;
  localparam int CW = $clog2(Q_W + 1);

  logic [RW-1:0]  rem_q, rem_d, dsh_q, dsh_d, cur_rem, cur_dsh;
  logic [Q_W-1:0] quot_q, quot_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;

  assign zero_o = (den_i == '0);
  assign ovf_o  = ~zero_o & (RW'(num_i) >= (RW'(den_i) << Q_W));
  assign done_o = run_q & (cnt_q == CW'(Q_W));
  assign quot_o = quot_q;

  always_comb begin
    rem_d  = rem_q;
    dsh_d  = dsh_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    // Operands are taken straight from the inputs on the first iteration, so
    // the caller may load them on the same edge that asserts start_i.
    cur_rem = (cnt_q == '0) ? RW'(num_i) : rem_q;
    cur_dsh = (cnt_q == '0) ? (RW'(den_i) << (Q_W - 1)) : dsh_q;
    if (start_i) begin
      cnt_d  = '0;
      run_d  = 1'b1;
      quot_d = '0;
    end else if (run_q && cnt_q != CW'(Q_W)) begin
      if (cur_rem >= cur_dsh) begin
        rem_d  = cur_rem - cur_dsh;
        quot_d = {quot_q[Q_W-2:0], 1'b1};
      end else begin
        rem_d  = cur_rem;
        quot_d = {quot_q[Q_W-2:0], 1'b0};
      end
      dsh_d = cur_dsh >> 1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dsh_q  <= dsh_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end
endmodule

// File: rtl/wb_awb_stats.sv
// AWB statistics: per-frame R/G/B sums of unsaturated pixels, then
// gain_r = G/R and gain_b = G/B in fixed point via two sequential dividers.
module wb_awb_stats
  import wb_awb_stats_pkg::*;
#(
  parameter int G_DATA_WIDTH = 8,
  parameter int G_COEF_WIDTH = 8,
  parameter int G_FRAC_WIDTH = 4,
  parameter int G_ACC_WIDTH  = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    frame_start_i,
  input  logic                    data_valid_i,
  input  logic [G_DATA_WIDTH-1:0] r_i,
  input  logic [G_DATA_WIDTH-1:0] g_i,
  input  logic [G_DATA_WIDTH-1:0] b_i,
  input  logic [G_DATA_WIDTH-1:0] sat_thresh_i,
  input  logic                    freeze_i,
  output logic [G_COEF_WIDTH-1:0] gain_r_o,
  output logic [G_COEF_WIDTH-1:0] gain_g_o,
  output logic [G_COEF_WIDTH-1:0] gain_b_o,
  output logic                    gain_valid_o,
  output logic                    busy_o
);
  localparam int NUM_W = G_ACC_WIDTH + G_FRAC_WIDTH;
  localparam logic [G_COEF_WIDTH-1:0] UNITY = G_COEF_WIDTH'(unity_gain(G_FRAC_WIDTH));
  localparam logic [63:0] ACC_MAX = 64'({G_ACC_WIDTH{1'b1}});

  wb_state_e                state_q, state_d;
  logic [G_ACC_WIDTH-1:0]   acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
  logic [G_ACC_WIDTH-1:0]   sr_q, sr_d, sg_q, sg_d, sb_q, sb_d;
  logic [G_COEF_WIDTH-1:0]  gain_r_q, gain_r_d, gain_b_q, gain_b_d;
  logic                     gain_valid_q, gain_valid_d;
  logic                     take, upd;
  logic [NUM_W-1:0]         num;
  logic [G_COEF_WIDTH-1:0]  q_r, q_b;
  logic                     z_r, z_b, o_r, o_b, done_r, done_b;

  function automatic logic [G_COEF_WIDTH-1:0] pick(input logic z, input logic o,
                                                   input logic [G_COEF_WIDTH-1:0] q);
    return z ? UNITY : (o ? {G_COEF_WIDTH{1'b1}} : q);
  endfunction

  // A pixel with any channel at or above threshold is dropped entirely.
  assign take = data_valid_i & ~((r_i >= sat_thresh_i) | (g_i >= sat_thresh_i) |
                                 (b_i >= sat_thresh_i));
  assign num  = {sg_q, {G_FRAC_WIDTH{1'b0}}};

  always_comb begin
    acc_r_d = frame_start_i ? '0 : acc_r_q;
    acc_g_d = frame_start_i ? '0 : acc_g_q;
    acc_b_d = frame_start_i ? '0 : acc_b_q;
    if (take) begin
      acc_r_d = G_ACC_WIDTH'(sat_add(64'(acc_r_d), 64'(r_i), ACC_MAX));
      acc_g_d = G_ACC_WIDTH'(sat_add(64'(acc_g_d), 64'(g_i), ACC_MAX));
      acc_b_d = G_ACC_WIDTH'(sat_add(64'(acc_b_d), 64'(b_i), ACC_MAX));
    end
    sr_d = frame_start_i ? acc_r_q : sr_q;
    sg_d = frame_start_i ? acc_g_q : sg_q;
    sb_d = frame_start_i ? acc_b_q : sb_q;
  end

  wb_seq_div #(.NUM_W(NUM_W), .DEN_W(G_ACC_WIDTH), .Q_W(G_COEF_WIDTH)) u_div_r (
    .clk_i, .rstn_i, .start_i(frame_start_i), .num_i(num), .den_i(sr_q),
    .quot_o(q_r), .zero_o(z_r), .ovf_o(o_r), .done_o(done_r));

  wb_seq_div #(.NUM_W(NUM_W), .DEN_W(G_ACC_WIDTH), .Q_W(G_COEF_WIDTH)) u_div_b (
    .clk_i, .rstn_i, .start_i(frame_start_i), .num_i(num), .den_i(sb_q),
    .quot_o(q_b), .zero_o(z_b), .ovf_o(o_b), .done_o(done_b));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      // Short-cut only when neither channel needs the iterative quotient.
      S_CHECK: state_d = ((z_r | o_r) & (z_b | o_b)) ? S_DONE : S_DIV;
      S_DIV:   if (done_r & done_b) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (frame_start_i) state_d = S_CHECK;
    // Gains load on the edge entering DONE so the pulse lines up with them.
    upd          = (state_d == S_DONE) & ~freeze_i;
    gain_valid_d = upd;
    gain_r_d     = upd ? pick(z_r, o_r, q_r) : gain_r_q;
    gain_b_d     = upd ? pick(z_b, o_b, q_b) : gain_b_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      acc_r_q      <= '0;
      acc_g_q      <= '0;
      acc_b_q      <= '0;
      sr_q         <= '0;
      sg_q         <= '0;
      sb_q         <= '0;
      gain_r_q     <= UNITY;
      gain_b_q     <= UNITY;
      gain_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_r_q      <= acc_r_d;
      acc_g_q      <= acc_g_d;
      acc_b_q      <= acc_b_d;
      sr_q         <= sr_d;
      sg_q         <= sg_d;
      sb_q         <= sb_d;
      gain_r_q     <= gain_r_d;
      gain_b_q     <= gain_b_d;
      gain_valid_q <= gain_valid_d;
    end
  end

  assign gain_r_o     = gain_r_q;
  assign gain_g_o     = UNITY;
  assign gain_b_o     = gain_b_q;
  assign gain_valid_o = gain_valid_q;
  assign busy_o       = (state_q == S_CHECK) || (state_q == S_DIV);
endmodule
